// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Two-port round-robin arbiter and access sequencer for a small register-file
// memory with asynchronous read. Port A and port B each issue one command at a
// time through a req/ack handshake. The arbiter grants one requester, latches
// its command, drives the memory for exactly one cycle, captures read data and
// returns a one-cycle ack pulse to the granted port.
//
// Ports:
//   clk        system clock, rising-edge
//   reset      synchronous active-high reset
//   req_a/b    request, held high by the requester until its ack
//   we_a/b     1 = write, 0 = read
//   addr_a/b   word address
//   wdata_a/b  write data
//   ack_a/b    one-cycle completion pulse
//   rdata_a/b  registered read data, held until the next read by that port
//   mem_we     memory write enable (high only in ACCESS, never during reset)
//   mem_addr   memory address (last latched command address)
//   mem_wdata  memory write data (last latched command data)
//   mem_rdata  memory read data, combinational in mem_addr
//   busy       high whenever the sequencer is not IDLE
// -----------------------------------------------------------------------------
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a request; arbitration and command latch on grant
// ACCESS | memory driven with the latched command; write commits / read
//        | data captured at the closing edge
// DONE   | ack pulse to the granted port
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic              ack_a,
    output logic [DATA_W-1:0] rdata_a,

    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              ack_b,
    output logic [DATA_W-1:0] rdata_b,

    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                sel_q, sel_d;
    logic                last_served_q, last_served_d;
    logic                cmd_we_q, cmd_we_d;
    logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
    logic [DATA_W-1:0]   rdata_a_q, rdata_a_d;
    logic [DATA_W-1:0]   rdata_b_q, rdata_b_d;
    logic                grant_b;

    // B wins when it is the only requester, or on a tie when A was served last.
    assign grant_b = req_b & (~req_a | ~last_served_q);

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        last_served_d = last_served_q;
        cmd_we_d      = cmd_we_q;
        cmd_addr_d    = cmd_addr_q;
        cmd_wdata_d   = cmd_wdata_q;
        rdata_a_d     = rdata_a_q;
        rdata_b_d     = rdata_b_q;

        case (state_q)
            IDLE: begin
                if (req_a || req_b) begin
                    sel_d         = grant_b;
                    last_served_d = grant_b;
                    if (grant_b) begin
                        cmd_we_d    = we_b;
                        cmd_addr_d  = addr_b;
                        cmd_wdata_d = wdata_b;
                    end else begin
                        cmd_we_d    = we_a;
                        cmd_addr_d  = addr_a;
                        cmd_wdata_d = wdata_a;
                    end
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!cmd_we_q) begin
                    if (sel_q) begin
                        rdata_b_d = mem_rdata;
                    end else begin
                        rdata_a_d = mem_rdata;
                    end
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            sel_q         <= 1'b0;
            last_served_q <= 1'b1;
            cmd_we_q      <= 1'b0;
            cmd_addr_q    <= '0;
            cmd_wdata_q   <= '0;
            rdata_a_q     <= '0;
            rdata_b_q     <= '0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            last_served_q <= last_served_d;
            cmd_we_q      <= cmd_we_d;
            cmd_addr_q    <= cmd_addr_d;
            cmd_wdata_q   <= cmd_wdata_d;
            rdata_a_q     <= rdata_a_d;
            rdata_b_q     <= rdata_b_d;
        end
    end

    // Reset masks the write enable combinationally: with a synchronous reset
    // the state is still ACCESS during the reset cycle, and the memory would
    // otherwise commit the aborted write at that edge.
    assign mem_we    = (state_q == ACCESS) & cmd_we_q & ~reset;
    assign mem_addr  = cmd_addr_q;
    assign mem_wdata = cmd_wdata_q;

    assign ack_a     = (state_q == DONE) & ~sel_q;
    assign ack_b     = (state_q == DONE) &  sel_q;
    assign rdata_a   = rdata_a_q;
    assign rdata_b   = rdata_b_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter. A behavioural 8 x 32 register file with
// asynchronous read sits on the memory port. Inputs change and outputs are
// sampled 1 time unit after each rising edge; "cycle k" below means the cycle
// after edge k-1, where edge 0 is the first edge that sees a new request.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_a, we_a, req_b, we_b;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [DATA_W-1:0] wdata_a, wdata_b;
    logic              ack_a, ack_b;
    logic [DATA_W-1:0] rdata_a, rdata_b;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic              mem_load;

    logic [DATA_W-1:0] mem_model [0:(1<<ADDR_W)-1];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_a     (req_a),
        .we_a      (we_a),
        .addr_a    (addr_a),
        .wdata_a   (wdata_a),
        .ack_a     (ack_a),
        .rdata_a   (rdata_a),
        .req_b     (req_b),
        .we_b      (we_b),
        .addr_b    (addr_b),
        .wdata_b   (wdata_b),
        .ack_b     (ack_b),
        .rdata_b   (rdata_b),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    // Preload word i with 0x1000_000i so untouched words have known contents.
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < (1 << ADDR_W); i++) begin
                mem_model[i] <= 32'h1000_0000 + i;
            end
        end else if (mem_we) begin
            mem_model[mem_addr] <= mem_wdata;
        end
    end

    assign mem_rdata = mem_model[mem_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        mem_load = 1'b1;
        req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
        req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
        cyc();
        mem_load = 1'b0;
        cyc();

        // Reset values
        chk("rst_busy",      {31'd0, busy},   32'd0);
        chk("rst_ack_a",     {31'd0, ack_a},  32'd0);
        chk("rst_ack_b",     {31'd0, ack_b},  32'd0);
        chk("rst_mem_we",    {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr",  {29'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_rdata_a",   rdata_a, 32'd0);
        chk("rst_rdata_b",   rdata_b, 32'd0);
        reset = 1'b0;

        // A write 0xDEADBEEF to word 3
        req_a = 1'b1; we_a = 1'b1; addr_a = 3'd3; wdata_a = 32'hDEAD_BEEF;
        cyc();  // cycle 1: ACCESS
        chk("wr_c1_mem_we",    {31'd0, mem_we}, 32'd1);
        chk("wr_c1_mem_addr",  {29'd0, mem_addr}, 32'd3);
        chk("wr_c1_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("wr_c1_busy",      {31'd0, busy}, 32'd1);
        chk("wr_c1_ack_a",     {31'd0, ack_a}, 32'd0);
        cyc();  // cycle 2: DONE
        chk("wr_c2_ack_a",   {31'd0, ack_a}, 32'd1);
        chk("wr_c2_ack_b",   {31'd0, ack_b}, 32'd0);
        chk("wr_c2_mem_we",  {31'd0, mem_we}, 32'd0);
        chk("wr_c2_rdata_a", rdata_a, 32'd0);
        req_a = 1'b0;
        cyc();  // cycle 3: IDLE
        chk("wr_c3_ack_a", {31'd0, ack_a}, 32'd0);
        chk("wr_c3_busy",  {31'd0, busy}, 32'd0);

        // A reads word 3 back
        req_a = 1'b1; we_a = 1'b0; addr_a = 3'd3;
        cyc();
        chk("rd_c1_mem_we",   {31'd0, mem_we}, 32'd0);
        chk("rd_c1_mem_addr", {29'd0, mem_addr}, 32'd3);
        cyc();
        chk("rd_c2_ack_a",   {31'd0, ack_a}, 32'd1);
        chk("rd_c2_mem_we",  {31'd0, mem_we}, 32'd0);
        chk("rd_c2_rdata_a", rdata_a, 32'hDEAD_BEEF);
        req_a = 1'b0;
        cyc();
        cyc();
        chk("rd_hold_rdata_a", rdata_a, 32'hDEAD_BEEF);

        // Simultaneous writes to word 5: A first after reset, then B
        do_reset();
        req_a = 1'b1; we_a = 1'b1; addr_a = 3'd5; wdata_a = 32'h1111_1111;
        req_b = 1'b1; we_b = 1'b1; addr_b = 3'd5; wdata_b = 32'h2222_2222;
        for (int c = 1; c <= 7; c++) begin
            cyc();
            chk($sformatf("sim_ack_a_c%0d", c), {31'd0, ack_a}, {31'd0, c == 2});
            chk($sformatf("sim_ack_b_c%0d", c), {31'd0, ack_b}, {31'd0, c == 5});
            if (ack_a) req_a = 1'b0;
            if (ack_b) req_b = 1'b0;
        end
        req_b = 1'b1; we_b = 1'b0; addr_b = 3'd5;
        cyc();
        cyc();
        chk("sim_rd_ack_b",   {31'd0, ack_b}, 32'd1);
        chk("sim_rd_rdata_b", rdata_b, 32'h2222_2222);
        req_b = 1'b0;
        cyc();

        // Round robin with both requests held continuously
        do_reset();
        req_a = 1'b1; we_a = 1'b0; addr_a = 3'd0;
        req_b = 1'b1; we_b = 1'b0; addr_b = 3'd1;
        for (int c = 1; c <= 12; c++) begin
            cyc();
            chk($sformatf("rr_ack_a_c%0d", c), {31'd0, ack_a}, {31'd0, (c == 2) || (c == 8)});
            chk($sformatf("rr_ack_b_c%0d", c), {31'd0, ack_b}, {31'd0, (c == 5) || (c == 11)});
        end
        req_a = 1'b0;
        req_b = 1'b0;
        cyc();
        chk("rr_rdata_a", rdata_a, 32'h1000_0000);
        chk("rr_rdata_b", rdata_b, 32'h1000_0001);

        // Reset during ACCESS of a B write to word 7
        req_b = 1'b1; we_b = 1'b1; addr_b = 3'd7; wdata_b = 32'hCAFE_F00D;
        cyc();  // ACCESS
        chk("ab_pre_mem_we", {31'd0, mem_we}, 32'd1);
        reset = 1'b1;
        req_b = 1'b0;
        #1;
        chk("ab_rst_mem_we", {31'd0, mem_we}, 32'd0);
        cyc();
        chk("ab_busy",  {31'd0, busy}, 32'd0);
        chk("ab_ack_b", {31'd0, ack_b}, 32'd0);
        reset = 1'b0;
        cyc();
        chk("ab_ack_b_after", {31'd0, ack_b}, 32'd0);
        chk("ab_busy_after",  {31'd0, busy}, 32'd0);
        req_a = 1'b1; we_a = 1'b0; addr_a = 3'd7;
        cyc();
        cyc();
        chk("ab_rd_ack_a",   {31'd0, ack_a}, 32'd1);
        chk("ab_rd_rdata_a", rdata_a, 32'h1000_0007);
        req_a = 1'b0;
        cyc();

        // Command change after grant has no effect
        req_a = 1'b1; we_a = 1'b0; addr_a = 3'd1;
        cyc();  // ACCESS
        addr_a = 3'd6;
        #1;
        chk("cc_mem_addr", {29'd0, mem_addr}, 32'd1);
        cyc();  // DONE
        chk("cc_ack_a",   {31'd0, ack_a}, 32'd1);
        chk("cc_rdata_a", rdata_a, 32'h1000_0001);
        req_a = 1'b0;
        cyc();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-port round-robin arbiter and access sequencer for the 8-word x 32-bit register-file memory with asynchronous read. Two requesters (port A, port B) share the single memory port through a req/ack handshake. The arbiter grants one requester, latches its command, and drives the memory's write_enable/address/data_in for exactly one cycle. It registers the read data and returns it with a one-cycle ack pulse.

Parameters:
DATA_W, 32, memory word width
ADDR_W, 3, memory address width (2**ADDR_W words)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
req_a  input  1  port A request, held high until ack_a
we_a  input  1  port A write (1) / read (0)
addr_a  input  ADDR_W  port A word address
wdata_a  input  DATA_W  port A write data
ack_a  output  1  one-cycle completion pulse to port A
rdata_a  output  DATA_W  registered read data for port A
req_b, we_b, addr_b, wdata_b, ack_b, rdata_b  same as port A, for port B
mem_we  output  1  to memory write_enable
mem_addr  output  ADDR_W  to memory address
mem_wdata  output  DATA_W  to memory data_in
mem_rdata  input  DATA_W  from memory data_out (combinational in mem_addr)
busy  output  1  high whenever state != IDLE

Behaviour:
- FSM states: IDLE, ACCESS, DONE. All outputs are registered or decoded from registered state.
- IDLE:
  - If req_a or req_b is high at the edge, pick a winner, latch its we/addr/wdata into cmd registers, set sel (0=A, 1=B), update last_served, and go to ACCESS.
  - With no request, stay in IDLE.
- Arbitration:
  - Single request: that port wins.
  - Both requesting: winner = !last_served. last_served = 1 after reset, so A wins the first tie.
  - last_served <= sel on every grant.
- ACCESS (exactly 1 cycle):
  - mem_addr = cmd_addr; mem_wdata = cmd_wdata; mem_we = cmd_we.
  - A write commits at the edge ending ACCESS.
  - For a read (cmd_we=0), that same edge captures mem_rdata into rdata_<sel>.
  - For a write, rdata_<sel> is unchanged.
  - Next state: DONE.
- DONE (exactly 1 cycle):
  - ack_<sel> = 1, the other ack = 0. mem_we = 0.
  - Next state: IDLE.
- Latency: req sampled at edge N -> ACCESS in cycle N+1 -> ack high in cycle N+2. A single requester gets at most one transaction per 3 cycles.
- Requester rule:
  - Hold req and command fields stable until ack is seen.
  - Drop req in the cycle after ack, or keep it high with a new command. A high req seen in IDLE is a new transaction.
  - The command is latched at grant, so changes after grant do not affect the current access.
- Outside ACCESS: mem_we = 0. mem_addr/mem_wdata hold the last cmd values (no glitch requirement on address).
- A losing requester keeps req high and is served next. No starvation: the maximum wait is one foreign transaction (3 cycles).
- Reset values: state=IDLE, ack_a=ack_b=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata_a=rdata_b=0, last_served=1, sel=0, busy=0.
- Reset mid-operation:
  - Abort immediately. No ack is issued for the aborted transaction.
  - mem_we = 0 during the reset cycle, so no write occurs even if reset is asserted during ACCESS.
  - Requesters must re-request.
- Width rules: addr passes through unmodified (no wrap logic needed; ADDR_W bits cover all words). Data is passed and captured at full DATA_W.

Test Plan:
- Reset then A write: req_a=1, we_a=1, addr_a=3, wdata_a=0xDEADBEEF at edge 0 -> mem_we=1, mem_addr=3 in cycle 1 only; ack_a=1 in cycle 2; ack_b stays 0; rdata_a stays 0.
- Read back: after the above, A reads addr 3 -> ack_a pulse 2 cycles after grant, rdata_a=0xDEADBEEF held until the next A read; mem_we=0 throughout.
- Simultaneous requests: after reset, A writes 0x11111111 @5 and B writes 0x22222222 @5, both asserted together -> A served first (ack_a at cycle 2), B next (ack_b at cycle 5); a subsequent read of 5 returns 0x22222222.
- Round-robin fairness: both reqs held high continuously for 12 cycles -> acks alternate A,B,A,B at cycles 2,5,8,11; never two consecutive acks to the same port.
- Reset mid-ACCESS: B write 0xCAFEF00D @7 granted, reset asserted in the ACCESS cycle -> mem_we=0 in that cycle, no ack_b, a later read of 7 returns the pre-existing value, and state=IDLE with busy=0 the cycle after reset.
- Command change after grant: A read of addr 1 granted, then addr_a changed to 6 in the ACCESS cycle -> mem_addr=1 and rdata_a=mem[1].
